// File: rtl/arbiter_client_port.sv
// Requester-side agent for the shared-bus round-robin arbiter: buffers local
// packets, requests the bus once a packet (or a full FIFO) is ready, drains it while granted.
module arbiter_client_port #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_WIDTH-1:0]      in_data,
    input  logic                       in_last,
    output logic                       request,
    input  logic                       grant,
    output logic                       acknowledge,
    output logic                       bus_valid,
    input  logic                       bus_ready,
    output logic [DATA_WIDTH-1:0]      bus_data,
    output logic                       bus_last,
    output logic                       grant_lost,
    output logic [$clog2(DEPTH):0]     level
);

    // state | meaning
    // IDLE  | nothing to send yet (no whole packet buffered, FIFO not full)
    // REQ   | request raised, waiting for grant
    // XFER  | granted, draining beats onto the bus until the last beat
    // ACK   | one-cycle acknowledge pulse, request dropped
    typedef enum logic [1:0] {IDLE, REQ, XFER, ACK} state_t;

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    state_t              state, next_state;
    logic [DATA_WIDTH:0] mem [DEPTH];
    logic [AW-1:0]       wr_ptr, rd_ptr;
    logic [LW-1:0]       level_q, pkt_cnt;
    logic [DATA_WIDTH:0] head;
    logic                push, pop, fifo_empty, fifo_full;
    logic                pkt_inc, pkt_dec;

    assign head       = mem[rd_ptr];
    assign fifo_empty = (level_q == '0);
    assign fifo_full  = (level_q == LW'(DEPTH));
    assign in_ready   = !fifo_full;
    assign push       = in_valid && in_ready;
    assign pop        = bus_valid && bus_ready;
    assign pkt_inc    = push && in_last;
    assign pkt_dec    = pop && bus_last;
    assign level      = level_q;

    // Bus outputs are forced to zero whenever no beat is being offered.
    assign bus_data = bus_valid ? head[DATA_WIDTH-1:0] : '0;
    assign bus_last = bus_valid && head[DATA_WIDTH];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {in_last, in_data};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level_q    <= '0;
            pkt_cnt    <= '0;
            state      <= IDLE;
            grant_lost <= 1'b0;
        end else begin
            state <= next_state;
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                level_q <= level_q + LW'(1);
            end else if (pop && !push) begin
                level_q <= level_q - LW'(1);
            end
            if (pkt_inc && !pkt_dec) begin
                pkt_cnt <= pkt_cnt + LW'(1);
            end else if (pkt_dec && !pkt_inc) begin
                pkt_cnt <= pkt_cnt - LW'(1);
            end
            // Leaving XFER only happens on the last handshake, so a low grant here is always premature.
            if (state == XFER && !grant) begin
                grant_lost <= 1'b1;
            end
        end
    end

    always_comb begin
        next_state  = state;
        request     = 1'b0;
        acknowledge = 1'b0;
        bus_valid   = 1'b0;
        case (state)
            IDLE: begin
                if (pkt_cnt != '0 || fifo_full) begin
                    next_state = REQ;
                end
            end
            REQ: begin
                request = 1'b1;
                if (grant) begin
                    next_state = XFER;
                end
            end
            XFER: begin
                request   = 1'b1;
                bus_valid = grant && !fifo_empty;
                if (bus_valid && bus_ready && head[DATA_WIDTH]) begin
                    next_state = ACK;
                end
            end
            ACK: begin
                acknowledge = 1'b1;
                next_state  = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

endmodule
